// File: rtl/axon_addr_gen.sv
// rtl/axon_addr_gen.sv - runtime-configurable base/len/stride address generator with burst and pass flags
// Optional loop counter output enabled by defining AXON_ADDR_LOOP_CNT_EN.
module axon_addr_gen #(
   parameter int ADDR_W     = 13,
   parameter int STRIDE_W   = 8,
   parameter int BURST_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                en,
   input  logic [ADDR_W-1:0]   cfg_base,
   input  logic [ADDR_W-1:0]   cfg_len,
   input  logic [STRIDE_W-1:0] cfg_stride,
   input  logic                cfg_wrap,
   output logic [ADDR_W-1:0]   addr_out,
   output logic                addr_valid,
   output logic                flag_burst,
   output logic                last,
   output logic                busy,
   output logic                done
`ifdef AXON_ADDR_LOOP_CNT_EN
   ,
   output logic [15:0]         loop_cnt
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state;
   logic [ADDR_W-1:0]   idx;
   logic [ADDR_W-1:0]   base_r;
   logic [ADDR_W-1:0]   len_r;
   logic [STRIDE_W-1:0] stride_r;
   logic                wrap_r;
   logic [ADDR_W-1:0]   len_m1;
   logic                at_end;
   logic                accept;

   // start is only honoured outside RUN and with a non-zero length
   assign accept = start && (cfg_len != '0) && (state != S_RUN);
   assign len_m1 = len_r - ADDR_W'(1);
   assign at_end = (idx == len_m1);

   assign busy       = (state == S_RUN);
   assign done       = (state == S_DONE);
   assign addr_valid = busy & en;
   assign last       = addr_valid & at_end;
   assign flag_burst = addr_valid & ((&idx[BURST_LOG2-1:0]) | at_end);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         addr_out <= '0;
         idx      <= '0;
         base_r   <= '0;
         len_r    <= '0;
         stride_r <= '0;
         wrap_r   <= 1'b0;
      end else if (accept) begin
         state    <= S_RUN;
         base_r   <= cfg_base;
         len_r    <= cfg_len;
         stride_r <= cfg_stride;
         wrap_r   <= cfg_wrap;
         addr_out <= cfg_base;
         idx      <= '0;
      end else if (state == S_RUN && en) begin
         if (at_end) begin
            if (wrap_r) begin
               idx      <= '0;
               addr_out <= base_r;
            end else begin
               state <= S_DONE;
            end
         end else begin
            idx      <= idx + ADDR_W'(1);
            addr_out <= addr_out + ADDR_W'(stride_r);
         end
      end else if (state != S_IDLE && state != S_RUN && state != S_DONE) begin
         state <= S_IDLE;
      end
   end

`ifdef AXON_ADDR_LOOP_CNT_EN
   // counts completed passes in either mode, saturating
   always_ff @(posedge clk) begin
      if (!rst) begin
         loop_cnt <= '0;
      end else if (accept) begin
         loop_cnt <= '0;
      end else if (last && loop_cnt != 16'hFFFF) begin
         loop_cnt <= loop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/axon_addr_gen.md
Name: axon_addr_gen

Overview:
Parametrised, runtime-configurable address generator for the AXON input-data path. It generalises the fixed 0..MAX_COUNT-1 address counter with the following:
- runtime base address, length and stride
- a start/busy/done handshake
- one-shot (hold at terminal) or circular (wrap) mode
- a burst flag with a parametrised period that also marks a partial final burst

It drives the read address of the input-data buffer and paces downstream burst consumers.

Parameters:
ADDR_W, 13, width of address and length fields
STRIDE_W, 8, width of stride field
BURST_LOG2, 4, flag_burst period = 2^BURST_LOG2 beats

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse; latches cfg_* and begins a pass
en  in  1  advance enable; 0 = pause
cfg_base  in  ADDR_W  first address
cfg_len  in  ADDR_W  number of beats per pass (0 = invalid)
cfg_stride  in  STRIDE_W  address increment per beat (unsigned)
cfg_wrap  in  1  1 = circular mode, 0 = one-shot
addr_out  out  ADDR_W  current address
addr_valid  out  1  addr_out consumed this cycle
flag_burst  out  1  last beat of a burst
last  out  1  last beat of a pass
busy  out  1  state RUN
done  out  1  level; one-shot pass complete

Behaviour:
- Reset is synchronous and active-low: reset takes effect on a clk edge while rst=0, not asynchronously.
- Reset values (rst=0 at a clk edge): state=IDLE, addr_out=0, idx=0, all flags 0; latched config cleared.
- Beat index idx is internal, ADDR_W bits wide.
- States:
  - IDLE -> RUN: start=1 and cfg_len!=0. Latch config; addr_out<=cfg_base; idx<=0.
  - RUN: a beat occurs in every cycle with en=1. At the edge: idx<=idx+1, addr_out<=addr_out+stride, modulo 2^ADDR_W (silent wrap-around).
  - RUN, beat with idx==len-1:
    - wrap=0: go to DONE; addr_out holds the terminal address.
    - wrap=1: idx<=0, addr_out<=base, stay in RUN; done never asserts.
  - DONE: done=1 and addr_out holds until reset or start. start with cfg_len!=0 -> RUN, same as from IDLE; done drops on that edge.
- start with cfg_len==0 is ignored in every state. start during RUN is ignored; config is not re-latched.
- Combinational outputs:
  - addr_valid = busy & en
  - last = addr_valid & (idx==len-1)
  - flag_burst = addr_valid & ((idx[BURST_LOG2-1:0]==all ones) | last)
- en=0 in RUN: all state holds; addr_valid, flag_burst and last are all 0. Resume continues at the same idx.
- Latency: first valid beat is the cycle after start (when en=1). Throughput is one beat per cycle.
- busy=1 only in RUN. flag_burst=0 in IDLE and DONE.
- rst=0 mid-pass: next cycle is IDLE with reset values; no done pulse.

Optional Feature:
AXON_ADDR_LOOP_CNT_EN:
- Defined: adds output loop_cnt [15:0].
  - Increments on every completed pass: the beat with last=1, in either mode.
  - Saturates at 0xFFFF.
  - Cleared to 0 on reset and on an accepted start.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. rst pulse low, start with base=0, len=512, stride=1, wrap=0, en=1 -> addr 0..511 over 512 cycles; flag_burst at addr 15, 31, ..., 511 (32 pulses); last at 511; next cycle done=1, busy=0; addr_out holds 511 with flag_burst=0 for 1024 further cycles.
2. base=100, len=20, stride=3 -> addresses 100, 103, ..., 157; flag_burst at idx 15 (addr 145) and idx 19 (addr 157, partial burst, last=1).
3. wrap=1, base=40, len=8, stride=1 -> 40..47 then 40 again; done stays 0; with AXON_ADDR_LOOP_CNT_EN, loop_cnt=3 after 24 beats.
4. en=0 for 3 cycles at idx 5 (addr 5) -> addr_out stays 5; addr_valid, flag_burst and last all 0; resume yields 5, 6, ...; a start pulse during RUN changes nothing.
5. rst=0 at idx 200 -> next cycle addr_out=0, busy=0, done=0; a new start restarts from cfg_base. Separately, start with cfg_len=0 -> remains in IDLE.
6. base=8190, len=4, stride=1 -> addresses 8190, 8191, 0, 1, then done=1 holding 1.
